writeback_queue: RTL
====================

// Module: writeback_queue
// PURPOSE
// Sits directly downstream of the execution stage's writeback mux and upstream of the register file write port.
// Accepts up to two register writebacks per cycle (reg1, reg2) and queues them in an in-order FIFO.
// Drains one write per cycle to the register file under a valid/ready handshake.
// Back-pressures execution through stall_o before the queue can overflow.
// PARAMETERS
// DEPTH            8   FIFO entries; power of two, >= 4
// PTR_WIDTH        3   log2(DEPTH)
// STALL_THRESHOLD  4   stall_o asserted when free slots < this value (covers 1 cycle of in-flight dual pushes)
// PORTS
// clock_i                  in   1   sole clock, rising edge
// reset_i                  in   1   asynchronous, active-low reset
// functionalUnitCode_i     in   2   producing unit ID; stored with each entry
// reg1WritebackEnable_i    in   1   push reg1 writeback this cycle
// reg2WritebackEnable_i    in   1   push reg2 writeback this cycle
// reg1WritebackAddress_i   in   6   destination of reg1 write
// reg2WritebackAddress_i   in   6   destination of reg2 write
// reg1WritebackVal_i       in   64  data of reg1 write
// reg2WritebackVal_i       in   64  data of reg2 write
// regWriteReady_i          in   1   register file accepts the presented write this cycle
// regWriteEnable_o         out  1   head entry valid (queue not empty)
// regWriteAddress_o        out  6   head entry address
// regWriteVal_o            out  64  head entry data
// regWriteUnitCode_o       out  2   head entry functional unit code
// stall_o                  out  1   back-pressure to execution/dispatch
// overflow_o               out  1   sticky: a push was dropped for lack of space
// occupancy_o              out  PTR_WIDTH+1  current entry count, 0..DEPTH
// BEHAVIOUR
// - Reset (reset_i=0, async): rd/wr pointers=0, count=0, overflow_o=0; hence regWriteEnable_o=0, stall_o=0,
//   occupancy_o=0; address/val/unitCode outputs=0. Entry storage need not be cleared. Reset mid-operation discards all entries.
// - Storage registered; head outputs driven from storage at rd pointer (no bypass): entry pushed at edge N is
//   presentable to register file from cycle after edge N. Empty queue drives regWriteEnable_o=0 and zero data.
// - Pop: occurs at edge when regWriteEnable_o=1 and regWriteReady_i=1; rd pointer advances by 1 (mod DEPTH).
//   regWriteReady_i ignored when empty.
// - Push order within a cycle: reg1 entry first, then reg2. Both enables with same address -> two entries, reg2 committed last (wins).
//   One enable only -> one entry. Both entries take the cycle's functionalUnitCode_i.
// - Space check uses free = DEPTH - count + pop (pop this cycle frees its slot for same-edge pushes).
//   free>=needed: all pushes accepted. free=1 with two requested: reg1 accepted, reg2 dropped. free=0: all dropped.
//   Any dropped push sets overflow_o=1 (held until reset).
// - count_next = count + accepted_pushes - pop; pointers wrap modulo DEPTH; count never exceeds DEPTH or underflows.
// - stall_o = (DEPTH - count) < STALL_THRESHOLD, from registered count (combinational, no same-cycle input path).
// - No state machine beyond FIFO control; simultaneous push+pop on empty queue: push accepted, no pop (head not yet visible).
// TESTING
// 1 Reset: assert reset_i=0 with 3 entries queued -> next cycle regWriteEnable_o=0, occupancy_o=0, stall_o=0, overflow_o=0.
// 2 Single push: reg1 en, addr 5, val 0xDEAD, ready=1 -> cycle+1 output addr 5/val 0xDEAD; popped at that edge; occupancy back to 0.
// 3 Dual push: reg1 (addr 3,val 1), reg2 (addr 3,val 2), ready=0 -> occupancy 2; release ready -> addr3/val1 then addr3/val2.
// 4 Fill: ready=0, dual pushes 3 cycles -> occupancy 6, stall_o=1 once free<4; 4th dual push -> occupancy 8, overflow_o stays 0.
// 5 Overflow: queue at 7, ready=0, dual push -> reg1 kept (occ 8), reg2 dropped, overflow_o=1 until reset.
// 6 Full+pop+dual push: occupancy 8, ready=1, dual push -> one pop, reg1 accepted, reg2 dropped; occupancy 8, FIFO order intact across pointer wrap.

Source files
------------

// File: rtl/writeback_queue.sv
// writeback_queue: dual-push, single-pop in-order writeback FIFO feeding the register file
module writeback_queue #(
    parameter int DEPTH           = 8,
    parameter int PTR_WIDTH       = 3,
    parameter int STALL_THRESHOLD = 4
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic [1:0]           functionalUnitCode_i,
    input  logic                 reg1WritebackEnable_i,
    input  logic                 reg2WritebackEnable_i,
    input  logic [5:0]           reg1WritebackAddress_i,
    input  logic [5:0]           reg2WritebackAddress_i,
    input  logic [63:0]          reg1WritebackVal_i,
    input  logic [63:0]          reg2WritebackVal_i,
    input  logic                 regWriteReady_i,
    output logic                 regWriteEnable_o,
    output logic [5:0]           regWriteAddress_o,
    output logic [63:0]          regWriteVal_o,
    output logic [1:0]           regWriteUnitCode_o,
    output logic                 stall_o,
    output logic                 overflow_o,
    output logic [PTR_WIDTH:0]   occupancy_o
);
    localparam logic [PTR_WIDTH:0] FULL   = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] THRESH = (PTR_WIDTH+1)'(STALL_THRESHOLD);
    localparam logic [PTR_WIDTH:0] TWO    = (PTR_WIDTH+1)'(2);

    logic [5:0]           addr_mem [DEPTH];
    logic [63:0]          val_mem  [DEPTH];
    logic [1:0]           unit_mem [DEPTH];
    logic [PTR_WIDTH-1:0] rd_ptr, wr_ptr, wr_next;
    logic [PTR_WIDTH:0]   count, free, need, acc;
    logic                 empty, pop, first_en, second_en;
    logic [5:0]           first_addr;
    logic [63:0]          first_val;

    // Pop/space arithmetic; reg1 always claims the first free slot, so a
    // lone reg2 push lands in the first slot too.
    always_comb begin
        empty      = count == '0;
        pop        = !empty && regWriteReady_i;
        free       = FULL - count + (PTR_WIDTH+1)'(pop);
        need       = (PTR_WIDTH+1)'(reg1WritebackEnable_i) + (PTR_WIDTH+1)'(reg2WritebackEnable_i);
        acc        = need > free ? free : need;
        first_en   = acc != '0;
        second_en  = acc == TWO;
        first_addr = reg1WritebackEnable_i ? reg1WritebackAddress_i : reg2WritebackAddress_i;
        first_val  = reg1WritebackEnable_i ? reg1WritebackVal_i : reg2WritebackVal_i;
        wr_next    = wr_ptr + PTR_WIDTH'(1);
    end

    // Pointer, count and sticky overflow state.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else begin
            rd_ptr <= rd_ptr + PTR_WIDTH'(pop);
            wr_ptr <= wr_ptr + acc[PTR_WIDTH-1:0];
            count  <= count + acc - (PTR_WIDTH+1)'(pop);
            if (need > free) overflow_o <= 1'b1;
        end
    end

    // Entry storage; contents are only meaningful between rd and wr pointers, so no reset.
    always_ff @(posedge clock_i) begin
        if (first_en) begin
            addr_mem[wr_ptr] <= first_addr;
            val_mem[wr_ptr]  <= first_val;
            unit_mem[wr_ptr] <= functionalUnitCode_i;
        end
        if (second_en) begin
            addr_mem[wr_next] <= reg2WritebackAddress_i;
            val_mem[wr_next]  <= reg2WritebackVal_i;
            unit_mem[wr_next] <= functionalUnitCode_i;
        end
    end

    assign regWriteEnable_o   = !empty;
    assign regWriteAddress_o  = empty ? '0 : addr_mem[rd_ptr];
    assign regWriteVal_o      = empty ? '0 : val_mem[rd_ptr];
    assign regWriteUnitCode_o = empty ? '0 : unit_mem[rd_ptr];
    assign occupancy_o        = count;
    assign stall_o            = (FULL - count) < THRESH;
endmodule
